message_serializer: RTL
=======================

# message_serializer

Parallel-to-serial front end for the message-detection path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `out_bit`, which drives the `in_bit` input of the downstream message detector. A one-word holding buffer lets back-to-back words stream with no idle gap. Idle cycles carry IDLE_BIT so the detector sees a defined, non-matching level.

## Interface
- WIDTH, 8, bits per word (≥2)
- MSB_FIRST, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
- IDLE_BIT, 0, value driven on `out_bit` when no word is being sent
- clk  in  1  clock, all state changes on its rising edge
- reset  in  1  synchronous, active-high
- data_in  in  WIDTH  word to serialize, sampled on accept
- load_valid  in  1  `data_in` is valid
- load_ready  out  1  block can accept a word this cycle
- out_bit  out  1  serial data, registered
- out_valid  out  1  `out_bit` carries a word bit, registered
- frame_done  out  1  high in the cycle that carries the last bit of a word, registered

## Operation
- Storage:
  - shift register `sh` (WIDTH)
  - bit counter `cnt`, $clog2(WIDTH) bits, counting 0..WIDTH-1
  - holding register `hold` with flag `hold_full`
  - FSM states IDLE and SHIFT
- Accept occurs on a rising edge where `load_valid && load_ready`.
- `load_ready` = !hold_full && !reset (combinational).
- Accept in IDLE:
  - word loads into `sh` and `cnt` = 0
  - FSM goes to SHIFT
  - first bit is on `out_bit` in the following cycle
- Accept in SHIFT, not on the last bit: word goes to `hold` and `hold_full` = 1.
- Accept in SHIFT on the last bit (`cnt` == WIDTH-1) with `hold` empty: bypass, word loads directly into `sh` and `cnt` = 0. No gap between words.
- End of word (`cnt` == WIDTH-1 at an edge):
  - `hold_full` = 1: `hold` moves to `sh`, `hold_full` clears, FSM stays in SHIFT.
  - Otherwise, with no bypass accept, FSM goes to IDLE. `out_valid` = 0 and `out_bit` = IDLE_BIT from the next cycle.
- Bit order:
  - MSB_FIRST = 1: bit i of the word is presented at `cnt` = WIDTH-1-i.
  - MSB_FIRST = 0: bit i is presented at `cnt` = i.
- `frame_done` is high exactly when `out_valid` = 1 and `cnt` = WIDTH-1.
- `data_in` is don't-care when no accept occurs. A word is never dropped or duplicated.

## Timing
- Reset, held at a rising edge:
  - FSM goes to IDLE, `hold_full` = 0, `cnt` = 0
  - `out_bit` = IDLE_BIT, `out_valid` = 0, `frame_done` = 0
  - `load_ready` = 0 while reset is high and 1 from the first cycle after release
- Reset mid-word discards both `sh` and `hold`. No partial bits follow.
- Latency: accept at edge k (IDLE) puts the first bit valid in cycle k+1 and the last bit in cycle k+WIDTH.
- Throughput: 1 bit/clock sustained, provided a new word is offered at least once during each word's WIDTH cycles.
- `hold_full` at the last bit: the transfer happens at the same edge, and `load_ready` rises the cycle after.
- `load_valid` may drop without an accept. No combinational path from `load_valid` to `load_ready`.

## Test plan
- Reset, then check output levels:
  - with IDLE_BIT = 0: `out_bit` = 0, `out_valid` = 0, `frame_done` = 0, `load_ready` = 1
  - with IDLE_BIT = 1: `out_bit` = 1
- Single word, MSB_FIRST = 1:
  - load 8'hF0 in IDLE → `out_bit` = 1,1,1,1,0,0,0,0 on cycles k+1..k+8, `frame_done` only at k+8, idle from k+9
  - with the detector downstream, its output pulses once
- Bit order, MSB_FIRST = 0: load 8'h01 → `out_bit` = 1,0,0,0,0,0,0,0.
- Back-to-back words:
  - offer 8'hAA, then 8'h55, with `load_valid` held high → 16 contiguous valid bits 10101010 01010101, no idle cycle
  - `load_ready` = 0 after the second accept, until the handoff
- Bypass and stall:
  - second word offered only in the last-bit cycle → loads with no gap
  - third word offered while `hold_full` → held off until the handoff, then accepted
- Reset mid-word: assert reset at bit 3 of 8'hFF → next cycle `out_valid` = 0 and `out_bit` = IDLE_BIT; the held word is also discarded.

Source files
------------

// File: rtl/message_serializer.sv
// message_serializer: parallel-to-serial front end with a one-word holding buffer
module message_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state, n_state;
    logic [WIDTH-1:0] sh, n_sh, hold;
    logic [CW-1:0]    cnt, n_cnt, idx;
    logic             hold_full, acc, last;

    assign load_ready = !hold_full && !reset;
    assign acc        = load_valid && load_ready;
    assign last       = state == S_SHIFT && cnt == LAST;

    // next word/position: start from idle, hand off from hold, bypass on the last bit, or advance
    always_comb begin
        n_state = state;
        n_sh    = sh;
        n_cnt   = cnt;
        if (state == S_IDLE) begin
            if (acc) begin
                n_state = S_SHIFT;
                n_sh    = data_in;
                n_cnt   = '0;
            end
        end else if (last) begin
            n_cnt = '0;
            if (hold_full) n_sh = hold;
            else if (acc) n_sh = data_in;
            else n_state = S_IDLE;
        end else begin
            n_cnt = cnt + CW'(1);
        end
        idx = MSB_FIRST ? LAST - n_cnt : n_cnt;
    end

    // state, holding buffer and registered serial outputs precomputed from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hold_full  <= 1'b0;
            out_bit    <= IDLE_BIT;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= n_state;
            sh         <= n_sh;
            cnt        <= n_cnt;
            out_valid  <= n_state == S_SHIFT;
            out_bit    <= n_state == S_SHIFT ? n_sh[idx] : IDLE_BIT;
            frame_done <= n_state == S_SHIFT && n_cnt == LAST;
            if (last && hold_full) begin
                hold_full <= 1'b0;
            end else if (acc && state == S_SHIFT && !last) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end
endmodule
